// File: rtl/collision_event_arbiter.sv
// collision_event_arbiter
//   Collects per-frame collision hits from NUM_SRC detectors, queues at most
//   one pending event per source and serialises them to a single consumer
//   over a valid/ready handshake with round-robin arbitration. A per-source
//   cooldown of whole frames keeps a long overlap from re-triggering.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   startOfFrame     one-cycle pulse at the start of each frame
//   collisionReq     raw per-pixel overlap, one bit per source
//   eventReady       consumer accepts the offered event this cycle
//   eventValid       an event is offered
//   eventId          source index of the offered event
//   pendingMask      sources with a queued, not-yet-offered event
//   frameEventCount  events transferred in the current frame (saturating)
//   droppedEvent     one-cycle pulse when a capture is lost
module collision_event_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int ID_W            = 2,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [NUM_SRC-1:0] collisionReq,
  input  logic               eventReady,
  output logic               eventValid,
  output logic [ID_W-1:0]    eventId,
  output logic [NUM_SRC-1:0] pendingMask,
  output logic [3:0]         frameEventCount,
  output logic               droppedEvent
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                  state_q;
  logic                    valid_q;
  logic [ID_W-1:0]         id_q;
  logic [ID_W-1:0]         rr_q;
  logic [NUM_SRC-1:0]      pending_q, pending_d;
  logic [NUM_SRC-1:0]      captured_q, captured_d;
  logic [NUM_SRC-1:0][3:0] cooldown_q, cooldown_d;
  logic [3:0]              count_q;
  logic                    dropped_q;

  logic [NUM_SRC-1:0]      capture;
  logic [NUM_SRC-1:0]      drop;
  logic [NUM_SRC-1:0]      grant_mask;
  logic                    xfer;
  logic                    found;
  logic                    hi_found;
  logic [ID_W-1:0]         hi_sel, lo_sel, sel;

  assign xfer = (state_q == OFFER) && valid_q && eventReady;

  // Round-robin pick: lowest pending index at or above the pointer,
  // otherwise wrap to the lowest pending index overall. The loop runs
  // downwards so the last assignment (lowest index) wins.
  always_comb begin
    hi_found = 1'b0;
    found    = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if (i >= int'(rr_q)) begin
          hi_found = 1'b1;
          hi_sel   = ID_W'(i);
        end
        found  = 1'b1;
        lo_sel = ID_W'(i);
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign grant_mask[gi] = (state_q == IDLE) && found && (sel == ID_W'(gi));

      // The frame-start clear applies before the capture test, so a hit in
      // the startOfFrame cycle belongs to the new frame.
      assign capture[gi] = collisionReq[gi]
                         && (startOfFrame || !captured_q[gi])
                         && (cooldown_q[gi] == 4'd0);

      assign captured_d[gi] = capture[gi] | (captured_q[gi] & ~startOfFrame);

      // A capture in the same cycle the source is granted re-queues it
      // instead of being counted as lost.
      assign drop[gi]      = capture[gi] & pending_q[gi] & ~grant_mask[gi];
      assign pending_d[gi] = capture[gi] | (pending_q[gi] & ~grant_mask[gi]);

      // Load on transfer takes precedence over the per-frame decrement.
      assign cooldown_d[gi] =
          (xfer && (id_q == ID_W'(gi)))           ? 4'(COOLDOWN_FRAMES) :
          (startOfFrame && cooldown_q[gi] != 4'd0) ? cooldown_q[gi] - 4'd1 :
                                                    cooldown_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      id_q       <= '0;
      rr_q       <= '0;
      pending_q  <= '0;
      captured_q <= '0;
      cooldown_q <= '0;
      count_q    <= 4'd0;
      dropped_q  <= 1'b0;
    end else begin
      captured_q <= captured_d;
      pending_q  <= pending_d;
      cooldown_q <= cooldown_d;
      dropped_q  <= |drop;

      if (startOfFrame) begin
        count_q <= xfer ? 4'd1 : 4'd0;
      end else if (xfer && count_q != 4'd15) begin
        count_q <= count_q + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (found) begin
            valid_q <= 1'b1;
            id_q    <= sel;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (eventReady) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
            if (id_q == ID_W'(NUM_SRC - 1)) begin
              rr_q <= '0;
            end else begin
              rr_q <= id_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eventValid      = valid_q;
  assign eventId         = id_q;
  assign pendingMask     = pending_q;
  assign frameEventCount = count_q;
  assign droppedEvent    = dropped_q;

endmodule

// File: tb/tb_collision_event_arbiter.sv
// Directed bench for collision_event_arbiter: a table of single-cycle
// vectors with hand-computed expected outputs, followed by hand-written
// multi-cycle sequences for once-per-frame capture and frame cooldown.
module tb_collision_event_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic [3:0] collisionReq = 4'b0;
  logic       eventReady = 1'b0;
  logic       eventValid;
  logic [1:0] eventId;
  logic [3:0] pendingMask;
  logic [3:0] frameEventCount;
  logic       droppedEvent;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  collision_event_arbiter #(
    .NUM_SRC(4),
    .ID_W(2),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .collisionReq(collisionReq),
    .eventReady(eventReady),
    .eventValid(eventValid),
    .eventId(eventId),
    .pendingMask(pendingMask),
    .frameEventCount(frameEventCount),
    .droppedEvent(droppedEvent)
  );

  typedef struct {
    logic       rst;
    logic       sof;
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] id;
    logic [3:0] pm;
    logic [3:0] cnt;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic sof, input logic [3:0] req,
                              input logic rdy, input logic v, input logic [1:0] id,
                              input logic [3:0] pm, input logic [3:0] cnt, input logic drop);
    vec_t t;
    t.rst = rst; t.sof = sof; t.req = req; t.rdy = rdy;
    t.v = v; t.id = id; t.pm = pm; t.cnt = cnt; t.drop = drop;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; outputs are then
  // observed 1 time unit after the following rising edge.
  task automatic cycle(input logic rst, input logic sof, input logic [3:0] req, input logic rdy);
    @(negedge clk);
    reset        = rst;
    startOfFrame = sof;
    collisionReq = req;
    eventReady   = rdy;
    @(posedge clk);
    #1;
  endtask

  int ev_cnt;
  int drop_cnt;
  int last_id;
  int exp_frame[5] = '{1, 0, 1, 0, 1};

  initial begin
    // Reset with assorted inputs, then single event latency.
    add(1, 1, 4'b1111, 1,  0, 0, 4'b0000, 0, 0);
    add(1, 0, 4'b0101, 0,  0, 0, 4'b0000, 0, 0);
    add(1, 1, 4'b1010, 1,  0, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b0010, 1,  0, 0, 4'b0010, 0, 0);
    add(0, 0, 4'b0000, 1,  1, 1, 4'b0000, 0, 0);
    add(0, 0, 4'b0000, 1,  0, 1, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 1, 4'b0000, 1, 0);
    // Round-robin with backpressure: 0, 1, 3.
    add(1, 0, 4'b0000, 0,  0, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b1011, 0,  0, 0, 4'b1011, 0, 0);
    add(0, 0, 4'b0000, 0,  1, 0, 4'b1010, 0, 0);
    add(0, 0, 4'b0000, 0,  1, 0, 4'b1010, 0, 0);
    add(0, 0, 4'b0000, 1,  0, 0, 4'b1010, 1, 0);
    add(0, 0, 4'b0000, 1,  1, 1, 4'b1000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 1, 4'b1000, 2, 0);
    add(0, 0, 4'b0000, 1,  1, 3, 4'b0000, 2, 0);
    add(0, 0, 4'b0000, 1,  0, 3, 4'b0000, 3, 0);
    add(0, 0, 4'b0000, 1,  0, 3, 4'b0000, 3, 0);
    // Drop: source 1 pending behind an offered source 0, new frame, re-hit.
    add(1, 0, 4'b0000, 0,  0, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b0011, 0,  0, 0, 4'b0011, 0, 0);
    add(0, 0, 4'b0000, 0,  1, 0, 4'b0010, 0, 0);
    add(0, 1, 4'b0000, 0,  1, 0, 4'b0010, 0, 0);
    add(0, 0, 4'b0010, 0,  1, 0, 4'b0010, 0, 1);
    add(0, 0, 4'b0010, 0,  1, 0, 4'b0010, 0, 0);
    add(0, 0, 4'b0000, 1,  0, 0, 4'b0010, 1, 0);
    add(0, 0, 4'b0000, 1,  1, 1, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 1, 4'b0000, 2, 0);
    // Simultaneity: capture on startOfFrame, repeat hit ignored,
    // pointer wrap, and transfer coinciding with startOfFrame.
    add(1, 0, 4'b0000, 0,  0, 0, 4'b0000, 0, 0);
    add(0, 1, 4'b1000, 1,  0, 0, 4'b1000, 0, 0);
    add(0, 0, 4'b0000, 1,  1, 3, 4'b0000, 0, 0);
    add(0, 0, 4'b1000, 1,  0, 3, 4'b0000, 1, 0);
    add(0, 0, 4'b1000, 1,  0, 3, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 3, 4'b0000, 1, 0);
    add(0, 0, 4'b0100, 1,  0, 3, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1,  1, 2, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 2, 4'b0000, 2, 0);
    add(0, 0, 4'b0001, 1,  0, 2, 4'b0001, 2, 0);
    add(0, 0, 4'b0000, 1,  1, 0, 4'b0000, 2, 0);
    add(0, 1, 4'b0000, 1,  0, 0, 4'b0000, 1, 0);
    add(0, 0, 4'b0000, 1,  0, 0, 4'b0000, 1, 0);

    foreach (vecs[r]) begin
      cycle(vecs[r].rst, vecs[r].sof, vecs[r].req, vecs[r].rdy);
      $display("vec %0d: rst=%0b sof=%0b req=%b rdy=%0b -> valid=%0b id=%0d pend=%b cnt=%0d drop=%0b",
               r, vecs[r].rst, vecs[r].sof, vecs[r].req, vecs[r].rdy,
               eventValid, eventId, pendingMask, frameEventCount, droppedEvent);
      check($sformatf("vec%0d eventValid", r), int'(eventValid), int'(vecs[r].v));
      check($sformatf("vec%0d eventId", r), int'(eventId), int'(vecs[r].id));
      check($sformatf("vec%0d pendingMask", r), int'(pendingMask), int'(vecs[r].pm));
      check($sformatf("vec%0d frameEventCount", r), int'(frameEventCount), int'(vecs[r].cnt));
      check($sformatf("vec%0d droppedEvent", r), int'(droppedEvent), int'(vecs[r].drop));
    end

    // Once per frame: source 2 overlapping for 200 cycles in one frame.
    cycle(1, 0, 4'b0000, 1);
    cycle(0, 1, 4'b0000, 1);
    ev_cnt = 0;
    drop_cnt = 0;
    last_id = -1;
    for (int c = 0; c < 200; c++) begin
      cycle(0, 0, 4'b0100, 1);
      if (eventValid) begin
        ev_cnt++;
        last_id = int'(eventId);
      end
      if (droppedEvent) drop_cnt++;
    end
    $display("once-per-frame: events=%0d last_id=%0d drops=%0d count=%0d",
             ev_cnt, last_id, drop_cnt, frameEventCount);
    check("oncepf events", ev_cnt, 1);
    check("oncepf eventId", last_id, 2);
    check("oncepf drops", drop_cnt, 0);
    check("oncepf frameEventCount", int'(frameEventCount), 1);

    // Cooldown: source 0 held high across five 12-cycle frames.
    cycle(1, 0, 4'b0000, 1);
    for (int f = 0; f < 5; f++) begin
      ev_cnt = 0;
      for (int c = 0; c < 12; c++) begin
        cycle(0, (c == 0), 4'b0001, 1);
        if (eventValid) ev_cnt++;
      end
      $display("cooldown frame %0d: events=%0d count=%0d", f, ev_cnt, frameEventCount);
      check($sformatf("cooldown frame%0d events", f), ev_cnt, exp_frame[f]);
      check($sformatf("cooldown frame%0d frameEventCount", f), int'(frameEventCount), exp_frame[f]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
